special_60s_timer: RTL and testbench

SPECIAL_60S_TIMER -- requirements
Module: special_60s_timer

---
 rtl/rpsc_timer_pkg.sv | 21 ++
 rtl/timed_delay.sv | 37 +++
 rtl/special_60s_timer.sv | 53 +++++
 tb/tb_special_60s_timer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rpsc_timer_pkg.sv
// rpsc_timer_pkg: timing constants shared by the permit-timer blocks.
// Define RPSC_FAST_SIM_EN to shrink one "second" to 4 clocks. The timer then
// fires after 240 edges instead of 46,875,000.
// No ports.
package rpsc_timer_pkg;

  localparam int unsigned CLK_PERIOD_NS = 1280;

`ifdef RPSC_FAST_SIM_EN
  localparam logic [19:0] PRESCALE_1S = 20'd4;
`else
  // 1 s / 1.28 us per clock
  localparam logic [19:0] PRESCALE_1S = 20'd781250;
`endif

  localparam logic [5:0]  SECONDS_TARGET = 6'd60;

  // 4 s at 1.28 us, used as a timed_delay target
  localparam logic [21:0] T4S_CYCLES = 22'd3125000;

endpackage

// File: rtl/timed_delay.sv
// timed_delay: asserts hit_target once in has been high for target
// consecutive rising edges. The counter saturates at target and never wraps.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset, clears the counter
//   target     - required number of high cycles (WIDTH bits)
//   in         - qualifying level; low clears the count
//   hit_target - combinational: in AND (count >= target)
module timed_delay #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             in,
  output logic             hit_target
);

  logic [WIDTH-1:0] count;

  // Consecutive-high counter, saturating at target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!in) begin
      count <= '0;
    end else if (count < target) begin
      count <= count + 1'b1;
    end else begin
      count <= count;
    end
  end

  // A >= compare means a target lowered mid-count takes effect at once
  assign hit_target = in && (count >= target);

endmodule

// File: rtl/special_60s_timer.sv
// special_60s_timer: asserts hit_target once in has been continuously high
// for 60 s. A 20-bit prescaler produces a one-second tick, and a 6-bit
// seconds counter saturates at 60. Any low cycle on in restarts the interval.
// Build option: RPSC_FAST_SIM_EN (see rpsc_timer_pkg) shortens the prescale.
// Ports:
//   clk        - rising-edge clock, nominal 1.28 us
//   reset      - asynchronous active-high reset, clears all counters
//   in         - qualifying level (typically the 4 s delayed permit)
//   hit_target - combinational: in AND (seconds == 60)
module special_60s_timer
  import rpsc_timer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic hit_target
);

  logic [19:0] prescale_count;
  logic [5:0]  seconds;
  logic        saturated;
  logic        sec_tick;

  assign saturated = (seconds == SECONDS_TARGET);
  // The tick fires on the edge where the prescaler wraps. It is suppressed
  // once saturated, which freezes the prescaler.
  assign sec_tick  = in && !saturated && (prescale_count == (PRESCALE_1S - 20'd1));

  // Prescaler and seconds counter; in low discards any partial time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_count <= 20'd0;
      seconds        <= 6'd0;
    end else if (!in) begin
      prescale_count <= 20'd0;
      seconds        <= 6'd0;
    end else if (!saturated) begin
      if (sec_tick) begin
        prescale_count <= 20'd0;
        seconds        <= seconds + 6'd1;
      end else begin
        prescale_count <= prescale_count + 20'd1;
        seconds        <= seconds;
      end
    end else begin
      prescale_count <= prescale_count;
      seconds        <= seconds;
    end
  end

  assign hit_target = in && saturated;

endmodule

// File: tb/tb_special_60s_timer.sv
// Testbench for special_60s_timer and timed_delay (WIDTH=4).
// The reference model tracks the number of consecutive high edges, which is
// all the outputs depend on. It is checked on every edge, together with
// hand-computed directed expectations.
module tb_special_60s_timer;

`ifdef RPSC_FAST_SIM_EN
  localparam int P = 4;
`else
  localparam int P = 781250;
`endif
  localparam int FULL = 60 * P;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b0;
  logic       hit_target;
  logic [3:0] td_target = 4'd15;
  logic       td_in = 1'b0;
  logic       td_hit;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;   // consecutive high edges seen by the top
  int tc = 0;  // timed_delay count model

  special_60s_timer dut (
    .clk(clk), .reset(reset), .in(in), .hit_target(hit_target)
  );

  timed_delay #(.WIDTH(4)) td (
    .clk(clk), .reset(reset), .target(td_target), .in(td_in), .hit_target(td_hit)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int top_hit_exp();
    return (in && !reset && n >= FULL) ? 1 : 0;
  endfunction

  function automatic int td_hit_exp();
    return (td_in && !reset && tc >= int'(td_target)) ? 1 : 0;
  endfunction

  // Model update on each edge, then check outputs and counters
  always @(posedge clk) begin
    if (reset) n = 0;
    else if (in) n = (n > FULL) ? n : n + 1;
    else n = 0;
    if (reset) tc = 0;
    else if (!td_in) tc = 0;
    else if (tc < int'(td_target)) tc = tc + 1;
    #1;
    check("hit_target", int'(hit_target), top_hit_exp());
    check("prescale", int'(dut.prescale_count), (n >= FULL) ? 0 : n % P);
    check("seconds", int'(dut.seconds), (n >= FULL) ? 60 : n / P);
    check("td_hit", int'(td_hit), td_hit_exp());
  end

  // Mid-cycle check: hit outputs must follow the inputs driven at negedge
  always @(negedge clk) begin
    #1;
    if (reset) begin
      n = 0;
      tc = 0;
    end
    check("hit_target_comb", int'(hit_target), top_hit_exp());
    check("td_hit_comb", int'(td_hit), td_hit_exp());
  end

  initial begin
    int run_left;
    int td_left;
    run_left = 0;
    td_left = 0;

    // Reset held with in high: everything stays zero
    in = 1'b1;
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      check("reset_hit", int'(hit_target), 0);
      check("reset_seconds", int'(dut.seconds), 0);
    end

    // timed_delay literal pins: target 15 fires on the 15th edge
    @(negedge clk);
    reset = 1'b0;
    in = 1'b0;
    td_target = 4'd15;
    td_in = 1'b1;
    repeat (14) @(posedge clk);
    #2 check("td_edge14", int'(td_hit), 0);
    @(posedge clk); #2 check("td_edge15", int'(td_hit), 1);
    @(negedge clk);
    td_target = 4'd0;
    td_in = 1'b0;
    #2 check("td_t0_low", int'(td_hit), 0);
    td_in = 1'b1;
    #2 check("td_t0_high", int'(td_hit), 1);

`ifdef RPSC_FAST_SIM_EN
    // Top literal pins: hit at edge 240, not 239, held while in stays high
    @(negedge clk);
    in = 1'b1;
    repeat (239) @(posedge clk);
    #2 check("top_edge239", int'(hit_target), 0);
    @(posedge clk); #2 check("top_edge240", int'(hit_target), 1);
    repeat (20) @(posedge clk);
    #2 check("top_held", int'(hit_target), 1);
    // Falls in the same cycle as in
    @(negedge clk);
    in = 1'b0;
    #2 check("top_fall", int'(hit_target), 0);
    // 200 high, one low edge, then a full fresh interval is required
    @(negedge clk);
    in = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    in = 1'b0;
    @(negedge clk);
    in = 1'b1;
    repeat (239) @(posedge clk);
    #2 check("glitch_239", int'(hit_target), 0);
    @(posedge clk); #2 check("glitch_240", int'(hit_target), 1);
    // Reset pulse at edge 120 restarts the count from release
    @(negedge clk);
    in = 1'b0;
    @(negedge clk);
    in = 1'b1;
    repeat (120) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (239) @(posedge clk);
    #2 check("rst120_239", int'(hit_target), 0);
    @(posedge clk); #2 check("rst120_240", int'(hit_target), 1);
`endif

    // Randomized runs, glitches, reset pulses and target changes
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 249) == 0);
      if (run_left == 0) begin
        if (!in) begin
          in = 1'b1;
          run_left = $urandom_range(1, 320);
        end else begin
          in = 1'b0;
          run_left = $urandom_range(1, 3);
        end
      end else begin
        run_left = run_left - 1;
      end
      if (td_left == 0) begin
        td_in = ~td_in;
        td_left = $urandom_range(1, 20);
      end else begin
        td_left = td_left - 1;
      end
      if ($urandom_range(0, 15) == 0) td_target = 4'($urandom_range(0, 15));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
